// File: rtl/fifo_pkg.sv
// Shared types for the FIFO: per-cycle operation encoding used by the occupancy update.
package fifo_pkg;

  // Encoded as {push_ok, pop_ok}
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x WIDTH register file, one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 i_clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally not reset; the pointers define validity
  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/fifo.sv
// First-word fall-through FIFO with register-array storage and registered empty/full/count.
// Optional sticky overflow/underflow flag o_err when FIFO_ERR_EN is defined.
module fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [WIDTH-1:0]            i_data,
  input  logic                        i_push,
  input  logic                        i_pop,
  output logic [WIDTH-1:0]            o_data,
  output logic                        o_empty,
  output logic                        o_full,
  output logic [$clog2(DEPTH):0]      o_count
`ifdef FIFO_ERR_EN
  ,
  output logic                        o_err
`endif
);

  localparam int unsigned ADDR_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_W     = ADDR_BITS + 1;

  logic [ADDR_BITS-1:0] rd_ptr_q;
  logic [ADDR_BITS-1:0] wr_ptr_q;
  logic                 push_ok;
  logic                 pop_ok;
  logic [CNT_W-1:0]     count_nxt;
  fifo_op_e             op;

  // A full queue still accepts a push when the head is popped in the same cycle
  assign push_ok = i_push & (~o_full | i_pop);
  assign pop_ok  = i_pop & ~o_empty;

  always_comb begin
    op        = fifo_op_e'({push_ok, pop_ok});
    count_nxt = o_count;
    case (op)
      OP_PUSH: count_nxt = o_count + CNT_W'(1);
      OP_POP:  count_nxt = o_count - CNT_W'(1);
      default: count_nxt = o_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      o_count  <= '0;
      o_empty  <= 1'b1;
      o_full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + ADDR_BITS'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + ADDR_BITS'(1);
      o_count <= count_nxt;
      o_empty <= (count_nxt == '0);
      o_full  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

`ifdef FIFO_ERR_EN
  // Sticky: overflow (push at full without pop) or underflow (pop at empty)
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_err <= 1'b0;
    end else if ((i_push & o_full & ~i_pop) | (i_pop & o_empty)) begin
      o_err <= 1'b1;
    end
  end
`endif

  fifo_mem #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .i_clk   (i_clk),
    .we      (push_ok),
    .waddr   (wr_ptr_q),
    .wdata   (i_data),
    .raddr   (rd_ptr_q),
    .rdata_c (o_data)
  );

endmodule
